// File: rtl/win_checker.sv
// ---------------------------------------------------------------------------
// win_checker
//
// Scans a Connect-Four board for a line of four same-coloured pieces.
// A scan takes a snapshot of the board when started, then examines one
// anchor cell per clock in row-major order. For every anchor it tests four
// lines that start at the anchor: horizontal to the right, vertical
// downward, diagonal down-right and diagonal down-left. The first anchor
// that completes a line decides the winner and ends the scan early.
//
// Parameters
//   ROWS  board rows; row 0 is the top, row ROWS-1 is the gravity row
//   COLS  board columns; column 0 is the leftmost
//
// Ports
//   clk          system clock, everything updates on the rising edge
//   rst          synchronous active-high reset
//   con4_matrix  board cells: 00 empty, 01 FPGA, 10 Arduino, 11 invalid
//   start        request a scan (only looked at while idle)
//   busy         high for every cycle in which an anchor is evaluated
//   done         one-cycle pulse when a scan completes
//   winner       01 FPGA won, 10 Arduino won, 00 no winner
//   draw         board full and nobody won
//   game_over    winner != 00 or draw (combinational)
//
// Handshake: start is a level request sampled only in IDLE; the cycle after
// it is accepted busy rises and stays high for exactly the evaluated
// anchors; the cycle after the last evaluated anchor busy falls and done
// pulses for one cycle; winner/draw are valid from that cycle and held
// until the next accepted start or reset. start seen while busy or done is
// dropped, never queued.
// ---------------------------------------------------------------------------
module win_checker #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [0:ROWS-1][0:COLS-1][1:0]      con4_matrix,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [1:0]                          winner,
    output logic                                draw,
    output logic                                game_over
);

    localparam int CELLS = ROWS * COLS;
    localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(CELLS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    localparam logic [1:0] CELL_EMPTY   = 2'b00;
    localparam logic [1:0] CELL_FPGA    = 2'b01;
    localparam logic [1:0] CELL_ARDUINO = 2'b10;
    localparam logic [1:0] CELL_INVALID = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    // Observable FSM state; assertions and external checkers bind to it.
    state_t                          state;

    logic [0:ROWS-1][0:COLS-1][1:0]  snap;
    logic [IW-1:0]                   anchor_idx;
    logic [RW-1:0]                   row_q;
    logic [CW-1:0]                   col_q;
    logic                            full;

    logic [1:0]                      anchor_val;
    logic                            anchor_colour;
    logic                            anchor_win;
    logic                            anchor_filled;

    // Snapshot read with bounds handling. Off-board positions read as the
    // invalid code, which can never equal a real piece colour, so a line
    // that leaves the board simply fails to match.
    function automatic logic [1:0] snap_cell(input int r, input int c);
        logic [1:0] v;
        v = CELL_INVALID;
        if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
            v = snap[r[RW-1:0]][c[CW-1:0]];
        end
        return v;
    endfunction

    // True when the three cells after the anchor along (dr,dc) all hold v.
    function automatic logic line_match(input int r, input int c,
                                        input int dr, input int dc,
                                        input logic [1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 1; i < 4; i++) begin
            if (snap_cell(r + dr * i, c + dc * i) != v) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    always_comb begin
        int ar;
        int ac;
        ar            = int'(row_q);
        ac            = int'(col_q);
        anchor_val    = snap_cell(ar, ac);
        anchor_colour = (anchor_val == CELL_FPGA) || (anchor_val == CELL_ARDUINO);
        anchor_filled = (anchor_val != CELL_EMPTY);
        anchor_win    = anchor_colour &&
                        (line_match(ar, ac, 0,  1, anchor_val) ||
                         line_match(ar, ac, 1,  0, anchor_val) ||
                         line_match(ar, ac, 1,  1, anchor_val) ||
                         line_match(ar, ac, 1, -1, anchor_val));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            winner     <= CELL_EMPTY;
            draw       <= 1'b0;
            anchor_idx <= '0;
            row_q      <= '0;
            col_q      <= '0;
            full       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        snap       <= con4_matrix;
                        winner     <= CELL_EMPTY;
                        draw       <= 1'b0;
                        anchor_idx <= '0;
                        row_q      <= '0;
                        col_q      <= '0;
                        full       <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SCAN;
                    end
                end

                SCAN: begin
                    if (anchor_win) begin
                        // First win in row-major order; later anchors are
                        // never looked at, so an earlier anchor always wins
                        // when both colours have a line.
                        winner <= anchor_val;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (anchor_idx == LAST_IDX) begin
                        // The last anchor's own emptiness still counts.
                        full  <= full & anchor_filled;
                        draw  <= full & anchor_filled;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        full       <= full & anchor_filled;
                        anchor_idx <= anchor_idx + 1'b1;
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign game_over = (winner != CELL_EMPTY) || draw;

    a_exclusive_result: assert property (@(posedge clk) disable iff (rst)
        !((winner != CELL_EMPTY) && draw));

    a_busy_is_scan: assert property (@(posedge clk) disable iff (rst)
        busy == (state == SCAN));

    a_done_is_done: assert property (@(posedge clk) disable iff (rst)
        done == (state == DONE));

endmodule

// File: tb/tb_win_checker.sv
// ---------------------------------------------------------------------------
// tb_win_checker
//
// Directed and randomized boards are driven into win_checker. For every
// accepted start the expected winner, draw flag and done latency are
// computed from the board by a plain search over all four-in-a-row lines
// and pushed into exp_q; a monitor pops and compares whenever done pulses,
// and checks busy/winner/draw/game_over on every other cycle.
// ---------------------------------------------------------------------------
module tb_win_checker;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int CELLS = ROWS * COLS;
  localparam int RB    = $clog2(ROWS);
  localparam int CB    = $clog2(COLS);

  typedef logic [0:ROWS-1][0:COLS-1][1:0] board_t;

  typedef struct {
    logic [1:0] w;
    logic       d;
    int         lat;
    int         sc;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  board_t     con4_matrix = '0;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic       draw;
  logic       game_over;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  win_checker #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk         (clk),
    .rst         (rst),
    .con4_matrix (con4_matrix),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .winner      (winner),
    .draw        (draw),
    .game_over   (game_over)
  );

  // ---------------- scoreboard state ----------------
  exp_t       exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  board_t     brd;
  logic [1:0] held_w = 2'b00;
  logic       held_d = 1'b0;
  int         busy_run = 0;
  bit         mon_en = 1'b0;
  bit         rst_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] bcell(input board_t b, input int r, input int c);
    return b[r[RB-1:0]][c[CB-1:0]];
  endfunction

  function automatic bit on_board(input int r, input int c);
    return (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
  endfunction

  // Walk anchors in row-major order; the first anchor that starts a full
  // on-board line of four identical pieces wins. Latency is anchor+2, or
  // CELLS+1 if the whole board was examined. Draw means no empty cell.
  function automatic void ref_eval(input board_t b, output logic [1:0] w,
                                   output logic d, output int lat);
    bit any_empty;
    any_empty = 1'b0;
    w   = 2'b00;
    d   = 1'b0;
    lat = CELLS + 1;
    for (int k = 0; k < CELLS; k++) begin
      int r;
      int c;
      logic [1:0] v;
      r = k / COLS;
      c = k % COLS;
      v = bcell(b, r, c);
      if (v == 2'b00) any_empty = 1'b1;
      if (v == 2'b01 || v == 2'b10) begin
        for (int j = 0; j < 4; j++) begin
          int dr;
          int dc;
          int same;
          dr = (j == 0) ? 0 : 1;
          dc = (j == 0) ? 1 : (j == 1) ? 0 : (j == 2) ? 1 : -1;
          if (on_board(r + 3 * dr, c + 3 * dc)) begin
            same = 0;
            for (int i = 0; i < 4; i++) begin
              if (bcell(b, r + i * dr, c + i * dc) == v) same++;
            end
            if (same == 4) begin
              w   = v;
              lat = k + 2;
              return;
            end
          end
        end
      end
    end
    d = !any_empty;
  endfunction

  // ---------------- board builders ----------------
  function automatic board_t rand_board(input int style);
    board_t b;
    b = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        int x;
        logic [1:0] v;
        x = int'($urandom_range(0, 9));
        case (style)
          0:       v = (x < 3) ? 2'b00 : (x < 6) ? 2'b01 : (x < 9) ? 2'b10 : 2'b11;
          1:       v = (x < 5) ? 2'b01 : 2'b10;
          default: v = (x < 6) ? 2'b00 : (x < 8) ? 2'b01 : 2'b10;
        endcase
        b[r[RB-1:0]][c[CB-1:0]] = v;
      end
    end
    return b;
  endfunction

  // Colour flips every column and every second row: no line of four.
  function automatic board_t draw_board(input bit invert);
    board_t b;
    b = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        bit p;
        p = (((r / 2) + c) % 2 == 1) ^ invert;
        b[r[RB-1:0]][c[CB-1:0]] = p ? 2'b10 : 2'b01;
      end
    end
    return b;
  endfunction

  // ---------------- driver ----------------
  // mode 0: quiet inputs during the scan
  // mode 1: random board and random start while scanning / in DONE
  // mode 2: board cleared to empty one cycle after start
  task automatic run_scan(input int mode);
    logic [1:0] w;
    logic       d;
    int         lat;
    ref_eval(brd, w, d, lat);
    @(posedge clk); #1;
    rst         = 1'b0;
    con4_matrix = brd;
    start       = 1'b1;
    exp_q.push_back('{w, d, lat, cyc});
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (mode == 1) begin
        start       = 1'($urandom_range(0, 1));
        con4_matrix = rand_board(0);
      end else if (mode == 2 && i == 1) begin
        con4_matrix = '0;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_prev) begin
        check("reset_busy",   int'(busy),   0);
        check("reset_done",   int'(done),   0);
        check("reset_winner", int'(winner), 0);
        check("reset_draw",   int'(draw),   0);
        check("reset_game_over", int'(game_over), 0);
      end else if (done) begin
        check("done_busy", int'(busy), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("winner",      int'(winner), int'(e.w));
          check("draw",        int'(draw),   int'(e.d));
          check("game_over",   int'(game_over), int'((e.w != 2'b00) || e.d));
          check("latency",     cyc - e.sc,   e.lat);
          check("busy_cycles", busy_run,     e.lat - 1);
          held_w = e.w;
          held_d = e.d;
        end
        busy_run = 0;
      end else if (busy) begin
        check("scan_winner",    int'(winner),    0);
        check("scan_draw",      int'(draw),      0);
        check("scan_game_over", int'(game_over), 0);
        held_w = 2'b00;
        held_d = 1'b0;
        busy_run++;
      end else begin
        check("held_winner",    int'(winner),    int'(held_w));
        check("held_draw",      int'(draw),      int'(held_d));
        check("held_game_over", int'(game_over), int'((held_w != 2'b00) || held_d));
      end
      if (rst) begin
        held_w   = 2'b00;
        held_d   = 1'b0;
        busy_run = 0;
      end
      rst_prev = rst;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [1:0] hw;
    logic       hd;
    int         hl;

    rst         = 1'b1;
    start       = 1'b0;
    con4_matrix = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // empty board: full 42-anchor scan, no winner, no draw
    brd = '0;
    run_scan(0);

    // bottom row 0..3 FPGA: win at anchor 35
    brd = '0;
    brd[5][0] = 2'b01; brd[5][1] = 2'b01; brd[5][2] = 2'b01; brd[5][3] = 2'b01;
    run_scan(0);

    // column 6 rows 2..5 Arduino, live board wiped after start
    brd = '0;
    brd[2][6] = 2'b10; brd[3][6] = 2'b10; brd[4][6] = 2'b10; brd[5][6] = 2'b10;
    run_scan(2);

    // full board, no line of four -> draw; then reset clears it
    brd = draw_board(1'b0);
    run_scan(0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // win at the very first anchor
    brd = '0;
    brd[0][0] = 2'b10; brd[0][1] = 2'b10; brd[0][2] = 2'b10; brd[0][3] = 2'b10;
    run_scan(0);

    // invalid cells never win; all-invalid board has no empty cell
    brd = '1;
    run_scan(0);
    brd = '0;
    brd[0][0] = 2'b11; brd[0][1] = 2'b11; brd[0][2] = 2'b11; brd[0][3] = 2'b11;
    brd[3][2] = 2'b01; brd[3][3] = 2'b01; brd[3][4] = 2'b01; brd[3][5] = 2'b01;
    run_scan(0);

    // down-left diagonal with start held through DONE: two scans exactly
    brd = '0;
    brd[0][3] = 2'b01; brd[1][2] = 2'b01; brd[2][1] = 2'b01; brd[3][0] = 2'b01;
    ref_eval(brd, hw, hd, hl);
    @(posedge clk); #1;
    con4_matrix = brd;
    start       = 1'b1;
    exp_q.push_back('{hw, hd, hl, cyc});
    for (int i = 1; i <= hl; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    exp_q.push_back('{hw, hd, hl, cyc});
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < hl + 2; i++) begin
      @(posedge clk); #1;
    end

    // reset in cycle 10 of a scan aborts it; start right after reset
    brd = '0;
    @(posedge clk); #1;
    con4_matrix = brd;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 2; i < 10; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    brd = rand_board(0);
    run_scan(0);

    // inverted draw pattern
    brd = draw_board(1'b1);
    run_scan(1);

    // randomized boards
    for (int n = 0; n < 45; n++) begin
      brd = rand_board(n % 3);
      run_scan(int'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/win_checker.md
WIN_CHECKER -- requirements
Module: win_checker

Interface
REQ-001 Parameter ROWS, default 6, board rows; row 0 is the top row and row ROWS-1 is the bottom (gravity) row.
REQ-002 Parameter COLS, default 7, board columns; column 0 is leftmost.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 con4_matrix  input  2 x [0:ROWS-1][0:COLS-1]  board cells: 00 empty, 01 FPGA piece, 10 Arduino piece, 11 invalid.
REQ-006 start  input  1  request one board scan; sampled only in IDLE.
REQ-007 busy  output  1  high while a scan is in progress.
REQ-008 done  output  1  single-cycle pulse marking scan completion.
REQ-009 winner  output  2  01 FPGA won, 10 Arduino won, 00 no winner.
REQ-010 draw  output  1  board full with no winner.
REQ-011 game_over  output  1  combinational OR of (winner != 00) and draw.

Function
REQ-012 FSM states are IDLE, SCAN and DONE.
REQ-013 IDLE with start=1: the block copies con4_matrix into an internal snapshot, clears winner/draw, sets the anchor index to 0 and the full flag to 1, then moves to SCAN.
REQ-014 The scan reads only the snapshot; changes to con4_matrix during SCAN have no effect.
REQ-015 SCAN checks one anchor cell (r,c) per cycle in row-major order, (0,0),(0,1)...(ROWS-1,COLS-1); one cycle per cell, 42 cycles at default size.
REQ-016 Per anchor, four lines are checked; a line is checked only if all 4 cells are in bounds:
- horizontal (r,c..c+3)
- vertical (r..r+3,c)
- diagonal down-right (r+i,c+i)
- diagonal down-left (r+i,c-i)
REQ-017 A line wins only if all 4 cells equal the anchor value and that value is 01 or 10; 00 and 11 never win.
REQ-018 Any anchor value of 00 during SCAN clears the full flag.
REQ-019 On the first winning anchor, winner takes the anchor value, the scan terminates early and the state moves to DONE the next cycle; remaining anchors are not examined.
REQ-020 Scan of the last anchor with no win: draw = full flag (including the last anchor's contribution); state moves to DONE.
REQ-021 DONE lasts one cycle; done=1 and busy=0 in that cycle; next state is IDLE.
REQ-022 busy=1 exactly in SCAN.
REQ-023 Latency: start sampled in cycle 0; anchor k is evaluated in cycle k+1; done pulses in cycle k+2 for a win at anchor k. With no win, done pulses in cycle ROWS*COLS+1 (cycle 43 at default size).
REQ-024 winner and draw hold their values after DONE until the next accepted start or reset.
REQ-025 start asserted in SCAN or DONE is ignored; it is not queued.
REQ-026 winner and draw are never both nonzero.
REQ-027 Only one winner is reported: the first winning anchor in row-major order. A board holding wins for both colours reports the earlier anchor.
REQ-028 Anchor index counter width is ceil(log2(ROWS*COLS)); it is never read beyond ROWS*COLS-1.

Reset
REQ-029 rst=1 at a clock edge forces IDLE, busy=0, done=0, winner=00, draw=0, anchor index 0 and full flag 0; the snapshot content is don't-care.
REQ-030 rst during SCAN aborts the scan with no done pulse; the block accepts start in the first cycle after rst deasserts.
REQ-031 rst has priority over start in the same cycle.

Verification
REQ-032 Empty board, start pulse -> busy high for 42 cycles, done pulses in cycle 43, winner=00, draw=0.
REQ-033 Bottom row cells (5,0..3)=01, start -> done in cycle 37 (anchor 35), winner=01, game_over=1.
REQ-034 Column 6, rows 2..5 = 10, with con4_matrix cleared to all-00 one cycle after start -> winner=10 at done (snapshot used), done in cycle 22 (anchor 20).
REQ-035 Full board in a no-four pattern of 01/10, start -> done in cycle 43, winner=00, draw=1. Then rst -> draw=0, winner=00.
REQ-036 Down-left diagonal (0,3),(1,2),(2,1),(3,0)=01 with start held high through DONE -> done at cycle 5, exactly one done pulse per accepted scan. A second scan starts only from IDLE.
REQ-037 rst asserted at cycle 10 of a scan -> no done pulse, busy=0 next cycle, winner=00; a new start then completes normally.
